// File: rtl/fmul_hp_arbiter_if.sv
// Request/response bundle between the two issuing clients, the consumer and fmul_hp_arbiter.
// The arbiter takes the slave modport; the issuing side takes the master modport.
interface fmul_hp_arbiter_if;
  logic        req0_valid;
  logic        req0_ready;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req1_valid;
  logic        req1_ready;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic [15:0] rsp_result;
  logic        rsp_ovf;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b, rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, rsp_ovf
  );
endinterface

// File: rtl/fmul_hp_arbiter.sv
// Round-robin two-client front end for the shared half-precision multiplier.
// Optional FMUL_ARB_OVF_SATURATE_EN: overflowing non-zero products become signed infinity.
module fmul_hp_arbiter (
  input logic             clk,
  input logic             rst_n,
  fmul_hp_arbiter_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StHold} state_e;

  state_e      state_q;
  logic        prio_q;
  logic        id_q;
  logic [15:0] opa_q;
  logic [15:0] opb_q;
  logic [15:0] result_q;
  logic        ovf_q;

  logic        gnt0;
  logic        gnt1;
  logic        in_idle;
  logic [15:0] win_a;
  logic [15:0] win_b;

  always_comb begin
    gnt0    = bus.req0_valid & (~bus.req1_valid | ~prio_q);
    gnt1    = bus.req1_valid & (~bus.req0_valid | prio_q);
    in_idle = (state_q == StIdle) & rst_n;
    win_a   = gnt1 ? bus.req1_a : bus.req0_a;
    win_b   = gnt1 ? bus.req1_b : bus.req0_b;
  end

  assign bus.req0_ready = in_idle & gnt0;
  assign bus.req1_ready = in_idle & gnt1;
  assign bus.rsp_valid  = (state_q == StHold);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.rsp_ovf    = ovf_q;

  // Multiplier datapath: biased exponent add, truncated and unnormalised mantissa product.
  logic        mul_zero;
  logic        mul_sign;
  logic [5:0]  exp_sum;
  logic [6:0]  exp_biased;
  logic [21:0] mant_prod;
  logic [4:0]  mul_exp;
  logic [9:0]  mul_mant;
  logic        mul_ovf;
  logic [15:0] mul_word;
  logic        unused_mul_bits;

  always_comb begin
    mul_zero   = (opa_q[14:0] == 15'd0) | (opb_q[14:0] == 15'd0);
    mul_sign   = opa_q[15] ^ opb_q[15];
    exp_sum    = {1'b0, opa_q[14:10]} + {1'b0, opb_q[14:10]};
    exp_biased = {1'b0, exp_sum} - 7'd15;
    mant_prod  = {1'b1, opa_q[9:0]} * {1'b1, opb_q[9:0]};
    mul_exp    = mul_zero ? 5'd0 : exp_biased[4:0];
    mul_mant   = mul_zero ? 10'd0 : mant_prod[19:10];
    mul_ovf    = ~mul_zero & (exp_sum > 6'd46);
`ifdef FMUL_ARB_OVF_SATURATE_EN
    mul_word   = mul_ovf ? {mul_sign, 5'b11111, 10'd0} : {mul_sign, mul_exp, mul_mant};
`else
    mul_word   = {mul_sign, mul_exp, mul_mant};
`endif
  end

  assign unused_mul_bits = ^{exp_biased[6:5], mant_prod[21:20], mant_prod[9:0]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      prio_q   <= 1'b0;
      id_q     <= 1'b0;
      opa_q    <= 16'd0;
      opb_q    <= 16'd0;
      result_q <= 16'd0;
      ovf_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (gnt0 | gnt1) begin
            opa_q   <= win_a;
            opb_q   <= win_b;
            id_q    <= gnt1;
            prio_q  <= ~gnt1;
            state_q <= StCalc;
          end
        end
        StCalc: begin
          result_q <= mul_word;
          ovf_q    <= mul_ovf;
          state_q  <= StHold;
        end
        StHold: begin
          if (bus.rsp_ready) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fmul_hp_arbiter.sv
// Directed bench for fmul_hp_arbiter: grants, latency, stalls, reset abort and arithmetic corners.
module tb_fmul_hp_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  fmul_hp_arbiter_if bus ();

  fmul_hp_arbiter dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef FMUL_ARB_OVF_SATURATE_EN
  localparam logic [15:0] OvfResult = 16'h7C00;
`else
  localparam logic [15:0] OvfResult = 16'h3400;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single-requester operation starting in IDLE with rsp_ready already high.
  task automatic run_op(input string tag, input int who, input logic [15:0] a,
                        input logic [15:0] b, input logic [15:0] exp_res, input logic exp_ovf);
    if (who == 0) begin
      bus.req0_valid = 1'b1; bus.req0_a = a; bus.req0_b = b;
    end else begin
      bus.req1_valid = 1'b1; bus.req1_a = a; bus.req1_b = b;
    end
    #1;
    check({tag, "_rdy0"}, bus.req0_ready, who == 0);
    check({tag, "_rdy1"}, bus.req1_ready, who == 1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    check({tag, "_calc_vld"}, bus.rsp_valid, 1'b0);
    step();
    check({tag, "_vld"}, bus.rsp_valid, 1'b1);
    check({tag, "_res"}, bus.rsp_result, exp_res);
    check({tag, "_ovf"}, bus.rsp_ovf, exp_ovf);
    check({tag, "_id"}, bus.rsp_id, who[0]);
    step();
    check({tag, "_done"}, bus.rsp_valid, 1'b0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rdy0"}, bus.req0_ready, 1'b0);
    check({tag, "_rdy1"}, bus.req1_ready, 1'b0);
    check({tag, "_vld"}, bus.rsp_valid, 1'b0);
    check({tag, "_id"}, bus.rsp_id, 1'b0);
    check({tag, "_res"}, bus.rsp_result, 16'h0000);
    check({tag, "_ovf"}, bus.rsp_ovf, 1'b0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    bus.req0_valid = 1'b0; bus.req0_a = 16'h0; bus.req0_b = 16'h0;
    bus.req1_valid = 1'b0; bus.req1_a = 16'h0; bus.req1_b = 16'h0;
    bus.rsp_ready  = 1'b1;
    #12;
    check_reset_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // 1.0 x 2.0 from req0
    run_op("basic", 0, 16'h3C00, 16'h4000, 16'h4000, 1'b0);
    // -0 x 1.0 from req1: signed zero; leaves prio favouring req0
    run_op("negzero", 1, 16'h8000, 16'h3C00, 16'h8000, 1'b0);

    // Both valid continuously: strict alternation 0, 1, 0
    bus.req0_valid = 1'b1; bus.req0_a = 16'hBC00; bus.req0_b = 16'h4000;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h0000; bus.req1_b = 16'h4000;
    for (int k = 0; k < 3; k++) begin
      int who;
      who = k % 2;
      #1;
      check($sformatf("alt%0d_rdy0", k), bus.req0_ready, who == 0);
      check($sformatf("alt%0d_rdy1", k), bus.req1_ready, who == 1);
      step();
      check($sformatf("alt%0d_calc_rdy", k), bus.req0_ready | bus.req1_ready, 1'b0);
      step();
      check($sformatf("alt%0d_vld", k), bus.rsp_valid, 1'b1);
      check($sformatf("alt%0d_id", k), bus.rsp_id, who[0]);
      check($sformatf("alt%0d_res", k), bus.rsp_result, (who == 0) ? 16'hC000 : 16'h0000);
      check($sformatf("alt%0d_hold_rdy", k), bus.req0_ready | bus.req1_ready, 1'b0);
      step();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    #1;

    // Overflow from req0 while the consumer stalls and req1 waits
    bus.rsp_ready  = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_a = 16'h7800; bus.req0_b = 16'h7800;
    #1;
    check("ovf_rdy0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h3C00; bus.req1_b = 16'h3C00;
    #1;
    check("ovf_calc_rdy1", bus.req1_ready, 1'b0);
    step();
    check("ovf_vld", bus.rsp_valid, 1'b1);
    check("ovf_res", bus.rsp_result, OvfResult);
    check("ovf_flag", bus.rsp_ovf, 1'b1);
    check("ovf_id", bus.rsp_id, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step();
      check($sformatf("stall%0d_vld", i), bus.rsp_valid, 1'b1);
      check($sformatf("stall%0d_res", i), bus.rsp_result, OvfResult);
      check($sformatf("stall%0d_rdy1", i), bus.req1_ready, 1'b0);
    end
    bus.rsp_ready = 1'b1;
    step();
    check("release_vld", bus.rsp_valid, 1'b0);
    check("release_rdy1", bus.req1_ready, 1'b1);
    step();
    bus.req1_valid = 1'b0;
    step();
    check("r1_vld", bus.rsp_valid, 1'b1);
    check("r1_res", bus.rsp_result, 16'h3C00);
    check("r1_id", bus.rsp_id, 1'b1);
    step();

    // Reset during CALC abandons the op; prio returns to favour req0
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4000; bus.req0_b = 16'h4000;
    #1;
    check("rstop_rdy0", bus.req0_ready, 1'b1);
    step();
    bus.req0_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("midcalc_rst");
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("postrst%0d_vld", i), bus.rsp_valid, 1'b0);
    end
    bus.req0_valid = 1'b1; bus.req0_a = 16'h4000; bus.req0_b = 16'h4000;
    bus.req1_valid = 1'b1; bus.req1_a = 16'h3C00; bus.req1_b = 16'h4000;
    #1;
    check("postrst_prio_rdy0", bus.req0_ready, 1'b1);
    check("postrst_prio_rdy1", bus.req1_ready, 1'b0);
    step();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    step();
    check("postrst_res", bus.rsp_result, 16'h4400);
    check("postrst_id", bus.rsp_id, 1'b0);
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
